counter_sched: RTL and testbench
================================

// Module: counter_sched
// PURPOSE
//  Round-robin scheduler sharing one CNT_W-bit up counter (the timer datapath) among NUM_REQ requesters.
//  Grants one requester at a time, clears the counter, enables it until it reaches that requester's
//  target count, then pulses done. Sits between client blocks and the shared counter instance.
// PARAMETERS
//  NUM_REQ  2  number of requesters (>=2)
//  CNT_W    4  counter width; targets are CNT_W bits
// PORTS
//  clk         in   1              rising-edge clock, single clock domain
//  reset       in   1              synchronous, active-high
//  req         in   NUM_REQ        level request per requester
//  tgt         in   NUM_REQ*CNT_W  target count, requester i in bits [i*CNT_W +: CNT_W]
//  gnt         out  NUM_REQ        one-hot grant, registered
//  done        out  NUM_REQ        one-cycle completion pulse, one-hot
//  busy        out  1              high in any state other than IDLE
//  cnt_reset   out  1              to counter reset input
//  cnt_enable  out  1              to counter enable input
//  cnt_value   in   CNT_W          counter output
// BEHAVIOUR
//  Counter contract: clears on cnt_reset at posedge; else increments on cnt_enable at posedge, wraps at 2^CNT_W.
//  Reset: state=IDLE, gnt=0, done=0, busy=0, cnt_enable=0, RR pointer selects requester 0 first.
//    cnt_reset = reset | (state==CLEAR), combinational, so the counter clears with this block.
//  FSM (2-bit): IDLE -> CLEAR -> RUN -> DONE -> IDLE.
//   IDLE : if |req, pick winner (RR: search from last_gnt+1 upward, wrap); next=CLEAR, latch winner,
//          latch tgt slice into tgt_q; else stay.
//   CLEAR: cnt_reset=1 for exactly one cycle; next=RUN.
//   RUN  : cnt_enable = (cnt_value != tgt_q); when cnt_value==tgt_q, next=DONE (enable low that cycle).
//   DONE : done[winner]=1 one cycle; update last_gnt=winner; next=IDLE.
//  gnt[winner] high in CLEAR, RUN, DONE; low in IDLE. done coincides with final gnt cycle.
//  Latency: req sampled at edge 0 -> gnt high from cycle 1 -> done high in cycle T+3 (T = target).
//  Minimum idle gap between runs: one IDLE cycle. Max T = 2^CNT_W-1; no overflow case exists.
//  Boundaries:
//   - T=0: RUN lasts one cycle with cnt_enable=0; done in cycle 3.
//   - req deasserted mid-run: ignored; run completes and done still pulses.
//   - tgt changed mid-run: ignored; tgt_q is the value latched in IDLE.
//   - all requesters continuously requesting: strict rotation 0,1,..,NUM_REQ-1,0.
//   - reset mid-run: immediate return to reset state; no done pulse for the aborted run.
// CONFIGURATION
//  COUNTER_SCHED_ABORT_EN defined: adds ports abort (in, 1) and aborted (out, 1).
//   abort high in CLEAR or RUN -> next=DONE, cnt_enable forced 0 that cycle; done pulses normally,
//   aborted=1 coincident with done. abort ignored in IDLE/DONE. aborted=0 at reset.
//  Not defined: ports absent; every run completes to target.
// STRUCTURE
//  Shared package counter_sched_pkg: state encodings IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, DONE=2'd3.
//  One sub-module: rr_arbiter (NUM_REQ) -- combinational req + last_gnt -> one-hot winner.
//  FSM, tgt_q, last_gnt registers and counter drive live in counter_sched.
// TESTING  (bench instantiates the real counter, CNT_W=4, NUM_REQ=2)
//  1. req=01, tgt0=5 -> gnt=01 cycle 1; cnt_enable 5 cycles; cnt_value 0..5; done=01 in cycle 8.
//  2. req=10, tgt1=0 -> gnt=10 cycle 1, cnt_enable never high, done=10 in cycle 3.
//  3. req=11 held, tgt0=2, tgt1=3 -> grant order 0,1,0,1; each done matches its own target timing.
//  4. req=01 tgt0=9, reset pulsed at cycle 5 -> all outputs 0 next cycle, no done; next req served fresh from 0.
//  5. req=01 tgt0=4, req dropped and tgt0 changed to 1 in cycle 3 -> run still counts to 4, done in cycle 7.
//  6. (ABORT_EN) req=01 tgt0=15, abort in cycle 4 -> done=01 and aborted=1 in cycle 5, cnt_value stops at 2.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types for the counter scheduler: FSM state encoding.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester above the last grant, wrapping to the
// lowest requester when none is above. Purely combinational; one-hot in, one-hot out.
module counter_sched_rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_last,
  output logic [NUM_REQ-1:0] o_winner
);

  localparam logic [NUM_REQ-1:0] One = NUM_REQ'(1);

  logic [NUM_REQ-1:0] w_upto;
  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_pool;

  // Mask off the last grant and everything below it, then isolate the lowest set bit
  always_comb begin
    w_upto   = (i_last << 1) - One;
    w_hi     = i_req & ~w_upto;
    w_pool   = (|w_hi) ? w_hi : i_req;
    o_winner = w_pool & (~w_pool + One);
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one up counter among NUM_REQ requesters.
// Optional feature: define COUNTER_SCHED_ABORT_EN to add i_abort / o_aborted.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*CNT_W-1:0] i_tgt,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_busy,
  output logic                     o_cnt_reset,
  output logic                     o_cnt_enable,
`ifdef COUNTER_SCHED_ABORT_EN
  input  logic                     i_abort,
  output logic                     o_aborted,
`endif
  input  logic [CNT_W-1:0]         i_cnt_value
);

  // Pointer starts on the top requester so requester 0 wins first after reset
  localparam logic [NUM_REQ-1:0] LastInit = {1'b1, {(NUM_REQ-1){1'b0}}};

  state_e             r_state;
  state_e             w_state_next;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_last;
  logic [NUM_REQ-1:0] w_winner;
  logic [CNT_W-1:0]   r_tgt;
  logic [CNT_W-1:0]   w_tgt_sel;
  logic               w_start;
  logic               w_at_tgt;
  logic               w_abort;

  counter_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_winner (w_winner)
  );

  assign w_start  = (r_state == StIdle) && (|i_req);
  assign w_at_tgt = (i_cnt_value == r_tgt);

`ifdef COUNTER_SCHED_ABORT_EN
  logic r_aborted;

  assign w_abort   = i_abort && ((r_state == StClear) || (r_state == StRun));
  assign o_aborted = (r_state == StDone) && r_aborted;

  // Remember whether the current run was cut short, shown alongside done
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_aborted <= 1'b0;
    end else if (w_start) begin
      r_aborted <= 1'b0;
    end else if (w_abort) begin
      r_aborted <= 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  // Select the winner's target slice for latching at grant time
  always_comb begin
    w_tgt_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner[i]) begin
        w_tgt_sel = i_tgt[i*CNT_W +: CNT_W];
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (|i_req) w_state_next = StClear;
      StClear: w_state_next = w_abort ? StDone : StRun;
      StRun:   if (w_at_tgt || w_abort) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Grant, latched target and round-robin pointer; tgt and req are ignored once granted
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gnt  <= '0;
      r_tgt  <= '0;
      r_last <= LastInit;
    end else if (w_start) begin
      r_gnt <= w_winner;
      r_tgt <= w_tgt_sel;
    end else if (r_state == StDone) begin
      r_gnt  <= '0;
      r_last <= r_gnt;
    end
  end

  // FSM outputs; cnt_reset follows block reset so the counter clears with us
  always_comb begin
    o_gnt        = r_gnt;
    o_busy       = (r_state != StIdle);
    o_cnt_reset  = i_reset | (r_state == StClear);
    o_cnt_enable = (r_state == StRun) && !w_at_tgt && !w_abort;
    o_done       = (r_state == StDone) ? r_gnt : '0;
  end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched (NUM_REQ=2, CNT_W=4) with a behavioural counter.
// Build with COUNTER_SCHED_ABORT_EN defined to also exercise the abort path.
module tb_counter_sched;

  localparam int N = 2;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] tgt = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic           cnt_reset;
  logic           cnt_enable;
  logic [W-1:0]   cnt;
`ifdef COUNTER_SCHED_ABORT_EN
  logic           abort = 1'b0;
  logic           aborted;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] t0;
    logic [W-1:0] t1;
    logic [N-1:0] gnt;
    int           t;
  } vec_t;

  vec_t vecs[6];

  counter_sched #(
    .NUM_REQ (N),
    .CNT_W   (W)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_tgt        (tgt),
    .o_gnt        (gnt),
    .o_done       (done),
    .o_busy       (busy),
    .o_cnt_reset  (cnt_reset),
    .o_cnt_enable (cnt_enable),
`ifdef COUNTER_SCHED_ABORT_EN
    .i_abort      (abort),
    .o_aborted    (aborted),
`endif
    .i_cnt_value  (cnt)
  );

  always #5 clk = ~clk;

  // Shared counter as described by the counter contract
  always_ff @(posedge clk) begin
    if (cnt_reset) cnt <= '0;
    else if (cnt_enable) cnt <= cnt + 4'd1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req   = '0;
    tgt   = '0;
`ifdef COUNTER_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait for a done pulse; cycle numbers continue from start_c. cyc = -1 if none in budget.
  task automatic wait_done(input int start_c, output int cyc, output logic [N-1:0] who,
                           output logic [W-1:0] cv);
    cyc = -1;
    who = '0;
    cv  = '0;
    for (int c = start_c + 1; c <= start_c + 40; c++) begin
      tick();
      @(negedge clk);
      if (done != '0) begin
        cyc = c;
        who = done;
        cv  = cnt;
        break;
      end
    end
  endtask

  // One table vector from a fresh reset: req pulses for one cycle at cycle 0
  task automatic run_vec(input vec_t v);
    int en_cnt;
    int done_cyc;
    en_cnt   = 0;
    done_cyc = -1;
    reset_dut();
    req = v.req;
    tgt = {v.t1, v.t0};
    tick();
    req = '0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) chk("vec_gnt_c1", gnt, v.gnt);
      if (cnt_enable) en_cnt++;
      if (done != '0) begin
        done_cyc = c;
        chk("vec_done_who", done, v.gnt);
        chk("vec_cnt_at_done", cnt, v.t);
        break;
      end
      tick();
    end
    chk("vec_done_cycle", done_cyc, v.t + 3);
    chk("vec_enable_cycles", en_cnt, v.t);
  endtask

  // Transaction-level reference: a run of target T occupies T+3 granted cycles
  task automatic random_phase(input int cycles);
    bit           m_active;
    int           m_e;
    int           m_t;
    int           m_win;
    int           m_last;
    bit           found;
    int           idx;
    logic [N-1:0] e_gnt;
    logic [6:0]   exp_v;
    logic [6:0]   act_v;
    int           e_cnt;
    m_active = 0;
    m_e      = 0;
    m_t      = 0;
    m_win    = 0;
    m_last   = N - 1;
    reset_dut();
    for (int k = 0; k < cycles; k++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) begin
        tgt = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 6))};
      end
      @(negedge clk);
      e_gnt = m_active ? (N'(1) << m_win) : '0;
      exp_v = {e_gnt,
               (m_active && m_e == m_t + 3) ? e_gnt : {N{1'b0}},
               m_active,
               m_active && m_e >= 2 && m_e <= m_t + 1,
               m_active && m_e == 1};
      act_v = {gnt, done, busy, cnt_enable, cnt_reset};
      chk("rand_outputs", act_v, exp_v);
      if (m_active && m_e >= 2) begin
        e_cnt = (m_e - 2 > m_t) ? m_t : m_e - 2;
        chk("rand_cnt", cnt, e_cnt);
      end
      @(posedge clk);
      if (m_active) begin
        if (m_e == m_t + 3) begin
          m_active = 0;
          m_last   = m_win;
        end else begin
          m_e++;
        end
      end else if (req != '0) begin
        found = 0;
        for (int s = 1; s <= N; s++) begin
          idx = (m_last + s) % N;
          if (!found && ((int'(req) >> idx) & 1) == 1) begin
            found = 1;
            m_win = idx;
          end
        end
        m_t      = (int'(tgt) >> (m_win * W)) & ((1 << W) - 1);
        m_e      = 1;
        m_active = 1;
      end
      #1;
    end
  endtask

  initial begin
    int           dc[$];
    logic [N-1:0] dw[$];
    int           ncyc;
    logic [N-1:0] who;
    logic [W-1:0] cv;
    int           ndone;
    int           exp_c[4];
    logic [N-1:0] exp_w[4];

    vecs[0] = '{2'b01, 4'd5,  4'd0,  2'b01, 5};
    vecs[1] = '{2'b10, 4'd0,  4'd0,  2'b10, 0};
    vecs[2] = '{2'b11, 4'd3,  4'd7,  2'b01, 3};
    vecs[3] = '{2'b10, 4'd9,  4'd15, 2'b10, 15};
    vecs[4] = '{2'b01, 4'd15, 4'd2,  2'b01, 15};
    vecs[5] = '{2'b11, 4'd0,  4'd1,  2'b01, 0};

    // Reset state
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_cnt_reset", cnt_reset, 1'b1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {gnt, done, busy, cnt_enable, cnt_reset}, 7'd0);
    chk("rst_cnt", cnt, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both requesting continuously: strict rotation with per-target timing
    exp_c = '{5, 12, 18, 25};
    exp_w = '{2'b01, 2'b10, 2'b01, 2'b10};
    reset_dut();
    req = 2'b11;
    tgt = {4'd3, 4'd2};
    for (int c = 1; c <= 30; c++) begin
      tick();
      @(negedge clk);
      if (done != '0) begin
        dc.push_back(c);
        dw.push_back(done);
      end
    end
    req = '0;
    chk("rr_done_count", dc.size(), 4);
    for (int k = 0; k < 4 && k < dc.size(); k++) begin
      chk("rr_done_cycle", dc[k], exp_c[k]);
      chk("rr_done_who", dw[k], exp_w[k]);
    end

    // Reset mid-run aborts without a done pulse; next request is served fresh
    reset_dut();
    req = 2'b01;
    tgt = {4'd0, 4'd9};
    tick();
    req = '0;
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cnt_reset", cnt_reset, 1'b1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {gnt, done, busy, cnt_enable}, 6'd0);
    chk("midrst_cnt", cnt, 0);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      @(negedge clk);
      if (done != '0) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    req = 2'b11;
    tgt = {4'd3, 4'd2};
    tick();
    req = '0;
    @(negedge clk);
    chk("midrst_fresh_gnt", gnt, 2'b01);
    wait_done(1, ncyc, who, cv);
    chk("midrst_fresh_done_cycle", ncyc, 5);
    chk("midrst_fresh_done_who", who, 2'b01);

    // req dropped and tgt changed mid-run: latched target still used
    reset_dut();
    req = 2'b01;
    tgt = {4'd0, 4'd4};
    tick();
    tick();
    tick();
    req = '0;
    tgt = {4'd0, 4'd1};
    wait_done(3, ncyc, who, cv);
    chk("late_chg_done_cycle", ncyc, 7);
    chk("late_chg_done_who", who, 2'b01);
    chk("late_chg_cnt", cv, 4);

`ifdef COUNTER_SCHED_ABORT_EN
    // Abort during RUN finishes early with aborted alongside done
    reset_dut();
    req = 2'b01;
    tgt = {4'd0, 4'd15};
    tick();
    req = '0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_enable_low", cnt_enable, 1'b0);
    chk("abort_cnt_c4", cnt, 2);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_done", done, 2'b01);
    chk("abort_flag", aborted, 1'b1);
    chk("abort_cnt_c5", cnt, 2);
    tick();
    @(negedge clk);
    chk("abort_flag_clear", aborted, 1'b0);
    chk("abort_cnt_c6", cnt, 2);
    chk("abort_idle", busy, 1'b0);
`endif

    random_phase(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
